// File: rtl/ula_pkg.sv
// Shared constants for the source-B operand stage: ext_mode encodings,
// operand buffer state encoding and a saturating counter helper.
package ula_pkg;

  localparam logic [1:0] EXT_PASS       = 2'b00;
  localparam logic [1:0] EXT_SIGN16     = 2'b01;
  localparam logic [1:0] EXT_ZERO16     = 2'b10;
  localparam logic [1:0] EXT_SIGN16_SL2 = 2'b11;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HALF  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ula_skid_buf.sv
// Two-entry in-order valid/ready buffer; data visible one cycle after accept into an empty buffer.
// in_ready comes only from registered state (low when full), so out_ready never reaches it combinationally.
module ula_skid_buf
  import ula_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  buf_state_t       state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             accept;
  logic             drain;

  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          head_d  = in_data;
          state_d = BUF_HALF;
        end
      end
      BUF_HALF: begin
        // Simultaneous accept and drain replaces the head in place.
        if (accept && drain) begin
          head_d = in_data;
        end else if (accept) begin
          tail_d  = in_data;
          state_d = BUF_FULL;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (drain) begin
          head_d  = tail_q;
          state_d = BUF_HALF;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/ula_src_b_stage.sv
// Selects one of NSRC operand words, applies the ext_mode transform and buffers it (1-cycle latency).
// Backpressure via a 2-entry buffer; illegal selects yield zero data, a flagged entry and a saturating count.
module ula_src_b_stage
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            ext_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [7:0]            err_count
);

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sext16;
  logic [WIDTH-1:0] xform;
  logic [WIDTH-1:0] captured;
  logic             illegal;
  logic             accept;

  // Out-of-range selects match no source, so word stays zero for them.
  always_comb begin
    word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        word = src_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  assign illegal = ({1'b0, sel} >= (SEL_W + 1)'(NSRC));
  assign sext16  = {{(WIDTH-16){word[15]}}, word[15:0]};

  always_comb begin
    xform = word;
    case (ext_mode)
      EXT_PASS:       xform = word;
      EXT_SIGN16:     xform = sext16;
      EXT_ZERO16:     xform = {{(WIDTH-16){1'b0}}, word[15:0]};
      EXT_SIGN16_SL2: xform = {sext16[WIDTH-3:0], 2'b00};
      default:        xform = word;
    endcase
  end

  assign captured = illegal ? '0 : xform;
  assign accept   = in_valid && in_ready;

  ula_skid_buf #(
    .WIDTH (WIDTH + 1)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({illegal, captured}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  ({sel_err, out_data}),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (accept && illegal) begin
      err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_ula_src_b_stage.sv
module tb_ula_src_b_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] src_bus;
  logic [2:0]   sel;
  logic [1:0]   ext_mode;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  // Reference: FIFO of expected {err, data} entries plus an error tally.
  logic [32:0] q[$];
  int          exp_cnt = 0;

  ula_src_b_stage #(.WIDTH(32), .NSRC(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_bus   (src_bus),
    .sel       (sel),
    .ext_mode  (ext_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_entry(input int s, input logic [1:0] m, input logic [159:0] bus);
    logic [159:0] sh;
    longint       w, low, sv, r;
    if (s >= 5) return {1'b1, 32'h0};
    sh  = bus >> (s * 32);
    w   = longint'(sh[31:0]);
    low = w % 65536;
    sv  = (low >= 32768) ? low - 65536 : low;
    case (m)
      2'd0:    r = w;
      2'd1:    r = sv;
      2'd2:    r = low;
      default: r = sv * 4;
    endcase
    return {1'b0, r[31:0]};
  endfunction

  task automatic step();
    bit          acc, drn;
    logic [32:0] dummy;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (drn) dummy = q.pop_front();
      if (acc) begin
        q.push_back(ref_entry(int'(sel), ext_mode, src_bus));
        if (int'(sel) >= 5 && exp_cnt < 255) exp_cnt++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 3'd7; ext_mode = 2'd0; src_bus = '1;
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_transforms();
    do_reset();
    src_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
    src_bus[1*32 +: 32] = 32'h0000_8004;
    sel = 3'd1; ext_mode = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8004 || sel_err !== 1'b0) begin
      errors++; $display("FAIL sign16 got v=%b d=%h e=%b want v=1 d=ffff8004 e=0", out_valid, out_data, sel_err); end
    step();
    src_bus[4*32 +: 32] = 32'h1234_FFFF;
    sel = 3'd4; ext_mode = 2'b11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hFFFF_FFFC || sel_err !== 1'b0) begin
      errors++; $display("FAIL sign16_sl2 got d=%h e=%b want fffffffc e=0", out_data, sel_err); end
    step();
    ext_mode = 2'b10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h0000_FFFF) begin errors++; $display("FAIL zero16 got %h want 0000ffff", out_data); end
    src_bus[4*32 +: 32] = 32'hDEAD_BEEF;
    ext_mode = 2'b00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pass got %h want deadbeef", out_data); end
    step();
  endtask

  task automatic test_illegal();
    do_reset();
    src_bus = '1; sel = 3'd7; ext_mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_data !== 32'h0 || sel_err !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL illegal_first got d=%h e=%b n=%0d want 0 1 1", out_data, sel_err, err_count); end
    repeat (299) step();
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got %0d want 255", err_count); end
    step();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_hold got %0d want 255", err_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] want[3];
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
    do_reset();
    src_bus = '0; sel = 3'd0; ext_mode = 2'b00; out_ready = 1'b0; in_valid = 1'b1;
    src_bus[31:0] = 32'hA; step();
    src_bus[31:0] = 32'hB; step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    src_bus[31:0] = 32'hC; sel = 3'd6; step(); step();
    checks++; if (out_data !== 32'hA || err_count !== 8'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold got d=%h n=%0d r=%b want a 0 0", out_data, err_count, in_ready); end
    sel = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== want[i]) begin
        errors++; $display("FAIL order_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, want[i]); end
      step();
      if (i == 1) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    do_reset();
    sel = 3'd2; ext_mode = 2'b00; src_bus = '0; out_ready = 1'b1; in_valid = 1'b1;
    prev = $urandom; src_bus[2*32 +: 32] = prev;
    step();
    for (int i = 0; i < 10; i++) begin
      src_bus[2*32 +: 32] = $urandom;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== prev) begin
        errors++; $display("FAIL b2b_%0d got v=%b r=%b d=%h want 1 1 %h", i, out_valid, in_ready, out_data, prev); end
      prev = src_bus[2*32 +: 32];
      step();
    end
    in_valid = 1'b0; step();
  endtask

  task automatic test_reset_full();
    do_reset();
    sel = 3'd5; src_bus = '1; ext_mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("FAIL prefull got r=%b n=%0d want 0 2", in_ready, err_count); end
    reset = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++; $display("FAIL reset_full got v=%b n=%0d want 0 0", out_valid, err_count); end
    reset = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset got r=%b v=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      ext_mode  = 2'($urandom_range(0, 3));
      src_bus   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step();
      checks++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rnd_hs_%0d got v=%b r=%b want v=%b r=%b", c, out_valid, in_ready, q.size() != 0, q.size() < 2); end
      checks++; if (err_count !== 8'(exp_cnt)) begin
        errors++; $display("FAIL rnd_cnt_%0d got %0d want %0d", c, err_count, exp_cnt); end
      if (q.size() != 0) begin
        checks++; if ({sel_err, out_data} !== q[0]) begin
          errors++; $display("FAIL rnd_data_%0d got e=%b d=%h want e=%b d=%h", c, sel_err, out_data, q[0][32], q[0][31:0]); end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; ext_mode = '0; src_bus = '0;
    test_reset();
    test_transforms();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
